// File: rtl/nasti_mem_arbiter.sv
// nasti_mem_arbiter: two-master to one-slave NASTI arbiter with independent round-robin write and read paths
module nasti_mem_arbiter #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      m0_aw_valid,
  output logic                      m0_aw_ready,
  input  logic [ID_WIDTH-1:0]       m0_aw_id,
  input  logic [ADDR_WIDTH-1:0]     m0_aw_addr,
  input  logic [7:0]                m0_aw_len,
  input  logic [2:0]                m0_aw_size,
  input  logic [USER_WIDTH-1:0]     m0_aw_user,
  input  logic                      m0_w_valid,
  output logic                      m0_w_ready,
  input  logic [DATA_WIDTH-1:0]     m0_w_data,
  input  logic [DATA_WIDTH/8-1:0]   m0_w_strb,
  input  logic                      m0_w_last,
  output logic                      m0_b_valid,
  input  logic                      m0_b_ready,
  output logic [ID_WIDTH-1:0]       m0_b_id,
  output logic [1:0]                m0_b_resp,
  output logic [USER_WIDTH-1:0]     m0_b_user,
  input  logic                      m0_ar_valid,
  output logic                      m0_ar_ready,
  input  logic [ID_WIDTH-1:0]       m0_ar_id,
  input  logic [ADDR_WIDTH-1:0]     m0_ar_addr,
  input  logic [7:0]                m0_ar_len,
  input  logic [2:0]                m0_ar_size,
  input  logic [USER_WIDTH-1:0]     m0_ar_user,
  output logic                      m0_r_valid,
  input  logic                      m0_r_ready,
  output logic [ID_WIDTH-1:0]       m0_r_id,
  output logic [DATA_WIDTH-1:0]     m0_r_data,
  output logic [1:0]                m0_r_resp,
  output logic                      m0_r_last,
  output logic [USER_WIDTH-1:0]     m0_r_user,
  input  logic                      m1_aw_valid,
  output logic                      m1_aw_ready,
  input  logic [ID_WIDTH-1:0]       m1_aw_id,
  input  logic [ADDR_WIDTH-1:0]     m1_aw_addr,
  input  logic [7:0]                m1_aw_len,
  input  logic [2:0]                m1_aw_size,
  input  logic [USER_WIDTH-1:0]     m1_aw_user,
  input  logic                      m1_w_valid,
  output logic                      m1_w_ready,
  input  logic [DATA_WIDTH-1:0]     m1_w_data,
  input  logic [DATA_WIDTH/8-1:0]   m1_w_strb,
  input  logic                      m1_w_last,
  output logic                      m1_b_valid,
  input  logic                      m1_b_ready,
  output logic [ID_WIDTH-1:0]       m1_b_id,
  output logic [1:0]                m1_b_resp,
  output logic [USER_WIDTH-1:0]     m1_b_user,
  input  logic                      m1_ar_valid,
  output logic                      m1_ar_ready,
  input  logic [ID_WIDTH-1:0]       m1_ar_id,
  input  logic [ADDR_WIDTH-1:0]     m1_ar_addr,
  input  logic [7:0]                m1_ar_len,
  input  logic [2:0]                m1_ar_size,
  input  logic [USER_WIDTH-1:0]     m1_ar_user,
  output logic                      m1_r_valid,
  input  logic                      m1_r_ready,
  output logic [ID_WIDTH-1:0]       m1_r_id,
  output logic [DATA_WIDTH-1:0]     m1_r_data,
  output logic [1:0]                m1_r_resp,
  output logic                      m1_r_last,
  output logic [USER_WIDTH-1:0]     m1_r_user,
  output logic                      s_aw_valid,
  input  logic                      s_aw_ready,
  output logic [ID_WIDTH:0]         s_aw_id,
  output logic [ADDR_WIDTH-1:0]     s_aw_addr,
  output logic [7:0]                s_aw_len,
  output logic [2:0]                s_aw_size,
  output logic [USER_WIDTH-1:0]     s_aw_user,
  output logic                      s_w_valid,
  input  logic                      s_w_ready,
  output logic [DATA_WIDTH-1:0]     s_w_data,
  output logic [DATA_WIDTH/8-1:0]   s_w_strb,
  output logic                      s_w_last,
  input  logic                      s_b_valid,
  output logic                      s_b_ready,
  input  logic [ID_WIDTH:0]         s_b_id,
  input  logic [1:0]                s_b_resp,
  input  logic [USER_WIDTH-1:0]     s_b_user,
  output logic                      s_ar_valid,
  input  logic                      s_ar_ready,
  output logic [ID_WIDTH:0]         s_ar_id,
  output logic [ADDR_WIDTH-1:0]     s_ar_addr,
  output logic [7:0]                s_ar_len,
  output logic [2:0]                s_ar_size,
  output logic [USER_WIDTH-1:0]     s_ar_user,
  input  logic                      s_r_valid,
  output logic                      s_r_ready,
  input  logic [ID_WIDTH:0]         s_r_id,
  input  logic [DATA_WIDTH-1:0]     s_r_data,
  input  logic [1:0]                s_r_resp,
  input  logic                      s_r_last,
  input  logic [USER_WIDTH-1:0]     s_r_user,
  output logic                      w_proto_err
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_t;
  typedef enum logic {R_IDLE, R_ADDR} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic wg, rg, last_w, last_r;
  logic [7:0] w_cnt, w_len;
  logic w_pick, r_pick, aw_hs, w_hs, ar_hs;
  // Round-robin: on a tie the master that did not finish last wins
  assign w_pick = (m0_aw_valid && m1_aw_valid) ? ~last_w : m1_aw_valid;
  assign r_pick = (m0_ar_valid && m1_ar_valid) ? ~last_r : m1_ar_valid;
  assign aw_hs = s_aw_valid && s_aw_ready;
  assign w_hs = s_w_valid && s_w_ready;
  assign ar_hs = s_ar_valid && s_ar_ready;
  // Write path: grant, forward AW, then stream W beats until last, checking beat count
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      w_state     <= W_IDLE;
      wg          <= 1'b0;
      last_w      <= 1'b1;
      w_cnt       <= 8'd0;
      w_len       <= 8'd0;
      w_proto_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (m0_aw_valid || m1_aw_valid) begin
          wg      <= w_pick;
          w_state <= W_ADDR;
        end
        W_ADDR: if (aw_hs) begin
          w_cnt   <= 8'd0;
          w_len   <= s_aw_len;
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_cnt <= w_cnt + 8'd1;
          if (s_w_last != (w_cnt == w_len)) w_proto_err <= 1'b1;
          if (s_w_last) begin
            w_state <= W_IDLE;
            last_w  <= wg;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  // Read path: grant and forward a single AR, independent of the write path
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state <= R_IDLE;
      rg      <= 1'b0;
      last_r  <= 1'b1;
    end else if (r_state == R_IDLE) begin
      if (m0_ar_valid || m1_ar_valid) begin
        rg      <= r_pick;
        r_state <= R_ADDR;
      end
    end else if (ar_hs) begin
      r_state <= R_IDLE;
      last_r  <= rg;
    end
  assign s_aw_valid  = (w_state == W_ADDR) && (wg ? m1_aw_valid : m0_aw_valid);
  assign s_aw_id     = {wg, wg ? m1_aw_id : m0_aw_id};
  assign s_aw_addr   = wg ? m1_aw_addr : m0_aw_addr;
  assign s_aw_len    = wg ? m1_aw_len : m0_aw_len;
  assign s_aw_size   = wg ? m1_aw_size : m0_aw_size;
  assign s_aw_user   = wg ? m1_aw_user : m0_aw_user;
  assign m0_aw_ready = (w_state == W_ADDR) && !wg && s_aw_ready;
  assign m1_aw_ready = (w_state == W_ADDR) && wg && s_aw_ready;
  assign s_w_valid   = (w_state == W_DATA) && (wg ? m1_w_valid : m0_w_valid);
  assign s_w_data    = wg ? m1_w_data : m0_w_data;
  assign s_w_strb    = wg ? m1_w_strb : m0_w_strb;
  assign s_w_last    = wg ? m1_w_last : m0_w_last;
  assign m0_w_ready  = (w_state == W_DATA) && !wg && s_w_ready;
  assign m1_w_ready  = (w_state == W_DATA) && wg && s_w_ready;
  assign s_ar_valid  = (r_state == R_ADDR) && (rg ? m1_ar_valid : m0_ar_valid);
  assign s_ar_id     = {rg, rg ? m1_ar_id : m0_ar_id};
  assign s_ar_addr   = rg ? m1_ar_addr : m0_ar_addr;
  assign s_ar_len    = rg ? m1_ar_len : m0_ar_len;
  assign s_ar_size   = rg ? m1_ar_size : m0_ar_size;
  assign s_ar_user   = rg ? m1_ar_user : m0_ar_user;
  assign m0_ar_ready = (r_state == R_ADDR) && !rg && s_ar_ready;
  assign m1_ar_ready = (r_state == R_ADDR) && rg && s_ar_ready;
  assign m0_b_valid  = s_b_valid && !s_b_id[ID_WIDTH];
  assign m1_b_valid  = s_b_valid && s_b_id[ID_WIDTH];
  assign m0_b_id     = s_b_id[ID_WIDTH-1:0];
  assign m1_b_id     = s_b_id[ID_WIDTH-1:0];
  assign m0_b_resp   = s_b_resp;
  assign m1_b_resp   = s_b_resp;
  assign m0_b_user   = s_b_user;
  assign m1_b_user   = s_b_user;
  assign s_b_ready   = s_b_id[ID_WIDTH] ? m1_b_ready : m0_b_ready;
  assign m0_r_valid  = s_r_valid && !s_r_id[ID_WIDTH];
  assign m1_r_valid  = s_r_valid && s_r_id[ID_WIDTH];
  assign m0_r_id     = s_r_id[ID_WIDTH-1:0];
  assign m1_r_id     = s_r_id[ID_WIDTH-1:0];
  assign m0_r_data   = s_r_data;
  assign m1_r_data   = s_r_data;
  assign m0_r_resp   = s_r_resp;
  assign m1_r_resp   = s_r_resp;
  assign m0_r_last   = s_r_last;
  assign m1_r_last   = s_r_last;
  assign m0_r_user   = s_r_user;
  assign m1_r_user   = s_r_user;
  assign s_r_ready   = s_r_id[ID_WIDTH] ? m1_r_ready : m0_r_ready;
endmodule

// File: doc/nasti_mem_arbiter.md
NASTI_MEM_ARBITER -- requirements
Module: nasti_mem_arbiter

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, master-side AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 128, data width; STRB width = DATA_WIDTH/8.
REQ-004 SHALL have parameter USER_WIDTH, default 1, user width.
REQ-005 SHALL have port clk, in, 1, clock; all state updates on posedge clk.
REQ-006 SHALL have port rstn, in, 1, reset, asynchronous, active-low.
REQ-007 SHALL have, for N in {0,1}, master AW bundle mN_aw_{valid in 1, ready out 1, id in ID_WIDTH, addr in ADDR_WIDTH, len in 8, size in 3, user in USER_WIDTH}.
REQ-008 SHALL have mN_w_{valid in 1, ready out 1, data in DATA_WIDTH, strb in DATA_WIDTH/8, last in 1}.
REQ-009 SHALL have mN_b_{valid out 1, ready in 1, id out ID_WIDTH, resp out 2, user out USER_WIDTH}.
REQ-010 SHALL have mN_ar_* with the same fields, widths and directions as mN_aw_*.
REQ-011 SHALL have mN_r_{valid out 1, ready in 1, id out ID_WIDTH, data out DATA_WIDTH, resp out 2, last out 1, user out USER_WIDTH}.
REQ-012 SHALL have slave bundles s_aw_*, s_w_*, s_b_*, s_ar_*, s_r_* with the same fields and opposite directions; s_*_id width = ID_WIDTH+1.
REQ-013 SHALL have port w_proto_err, out, 1, sticky: W beat count disagreed with AW len.

Function
REQ-014 Write FSM SHALL have states W_IDLE, W_ADDR, W_DATA.
REQ-015 In W_IDLE with any mN_aw_valid, SHALL register grant wg and go to W_ADDR; when both request, grant the master not in last_w (round-robin).
REQ-016 In W_ADDR SHALL forward mN_aw of master wg to s_aw with s_aw_id = {wg, mN_aw_id}; on s_aw_valid&&s_aw_ready go to W_DATA; clear beat counter to 0.
REQ-017 In W_DATA SHALL forward mN_w of master wg to s_w; each s_w handshake increments 8-bit beat counter.
REQ-018 On s_w handshake with last=1 SHALL go to W_IDLE and set last_w = wg.
REQ-019 SHALL set w_proto_err when the handshaked beat has last=1 and count != latched len, or last=0 and count == len; SHALL hold it until reset.
REQ-020 Read FSM SHALL have states R_IDLE, R_ADDR; R_IDLE arbitrates mN_ar_valid round-robin via last_r into grant rg; R_ADDR forwards with s_ar_id = {rg, mN_ar_id}; on s_ar handshake returns to R_IDLE, last_r = rg.
REQ-021 Grant latency SHALL be exactly one cycle: a request seen in *_IDLE at edge k appears on the slave channel from cycle k+1.
REQ-022 Non-granted or idle-state master SHALL see *_ready = 0; slave s_aw/s_w/s_ar valid SHALL be 0 outside W_ADDR/W_DATA/R_ADDR respectively.
REQ-023 Grant SHALL be held until the slave handshake even if the granted master deasserts valid (slave valid then follows master valid, = 0).
REQ-024 B routing SHALL be combinational: mN_b_valid = s_b_valid && s_b_id[ID_WIDTH]==N; mN_b_id = s_b_id[ID_WIDTH-1:0]; s_b_ready = selected master's b_ready.
REQ-025 R routing SHALL be identical to B using s_r_id[ID_WIDTH], including data/last/resp/user fan-out.
REQ-026 Read and write FSMs SHALL operate independently and concurrently; a grant to one master on AW SHALL NOT block the other master on AR.
REQ-027 W data SHALL NOT be accepted before its AW grant (no W-before-AW).

Reset
REQ-028 On rstn low SHALL asynchronously enter W_IDLE/R_IDLE, set last_w = last_r = 1 (master 0 wins first tie), clear beat counter and w_proto_err.
REQ-029 During reset all master ready and slave valid outputs SHALL be 0; B/R routed valids follow s_b_valid/s_r_valid.
REQ-030 Reset mid-burst SHALL abandon the burst; no beat resumes after rstn rises.

Verification
REQ-031 Both masters assert AW (len=3) same cycle after reset -> m0 granted first, 4 W beats from m0, then m1 granted; s_aw_id MSB 0 then 1.
REQ-032 m0 write len=0 while m1 read in flight -> AW and AR forwarded in same cycle, both complete without stall.
REQ-033 s_b_id = {1,id=1}, resp=2 -> only m1_b_valid=1, m1_b_id=1, m1_b_resp=2; m0_b_valid=0.
REQ-034 m0 AW len=2, sends last on beat 1 -> w_proto_err=1 after that edge, stays 1 until rstn.
REQ-035 rstn pulsed low in W_DATA after 2 of 4 beats -> all ready/valid 0 next sample, FSM W_IDLE, m0 wins next tie.
REQ-036 m1 streams reads back-to-back, m0 issues one read -> m0 granted within 2 arbitration rounds (no starvation).
